// File: rtl/key_debounce_if.sv
// Purpose: bundles the raw button input with the debounced level and event pulses.
// Latency: none, wiring only.
// Backpressure: none; the pulses are fire-and-forget single-cycle events.
//
// Signals:
//   key_n       raw button, low = pressed, asynchronous to the clock
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse on an accepted press
//   key_release one-cycle pulse on an accepted release
//   key_long    one-cycle pulse once per press after the hold time
// master = debouncer side, slave = button source / pulse consumer side.
interface key_debounce_if;
   logic key_n;
   logic key_state;
   logic key_press;
   logic key_release;
   logic key_long;

   modport master (
      input  key_n,
      output key_state,
      output key_press,
      output key_release,
      output key_long
   );

   modport slave (
      output key_n,
      input  key_state,
      input  key_press,
      input  key_release,
      input  key_long
   );
endinterface

// File: rtl/key_debounce.sv
// Purpose: debounces one active-low push-button into a clean level plus press/release/long-press pulses.
// Latency: press/release pulse CNT_DEBOUNCE+3 edges after the first edge sampling the new level; long pulse CNT_LONG+1 edges after press.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
//
// Ports:
//   clk    system clock (12 MHz), all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    key_debounce_if.master: key_n in; key_state, key_press, key_release, key_long out
module key_debounce #(
   parameter int CNT_DEBOUNCE = 240_000 - 1,
   parameter int CNT_LONG     = 12_000_000 - 1,
   parameter int DB_W         = 18,
   parameter int LONG_W       = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   key_debounce_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_FLT = 2'd1,
      DOWN      = 2'd2,
      REL_FLT   = 2'd3
   } state_t;

   // The cycle in which IDLE/DOWN first sees the new level is itself the
   // first of the CNT_DEBOUNCE+1 stable samples, so the filter state only
   // needs to see CNT_DEBOUNCE more. That puts acceptance on edge
   // CNT_DEBOUNCE+3 counted from the first edge sampling key_n.
   // CNT_DEBOUNCE must therefore be at least 1.
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(CNT_DEBOUNCE - 1);
   localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(CNT_LONG);

   // Two-flop synchronizer, idles high (released).
   logic r_sync1;
   logic r_key_s;

   state_t            r_state,       w_state_nxt;
   logic [DB_W-1:0]   r_db_cnt,      w_db_cnt_nxt;
   logic [LONG_W-1:0] r_hold_cnt,    w_hold_cnt_nxt;
   logic              r_long_done,   w_long_done_nxt;
   logic              r_key_state,   w_key_state_nxt;
   logic              r_key_press,   w_key_press_nxt;
   logic              r_key_release, w_key_release_nxt;
   logic              r_key_long,    w_key_long_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_key_s <= 1'b1;
      end else begin
         r_sync1 <= bus.key_n;
         r_key_s <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_db_cnt      <= '0;
         r_hold_cnt    <= '0;
         r_long_done   <= 1'b0;
         r_key_state   <= 1'b0;
         r_key_press   <= 1'b0;
         r_key_release <= 1'b0;
         r_key_long    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_db_cnt      <= w_db_cnt_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_long_done   <= w_long_done_nxt;
         r_key_state   <= w_key_state_nxt;
         r_key_press   <= w_key_press_nxt;
         r_key_release <= w_key_release_nxt;
         r_key_long    <= w_key_long_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_db_cnt_nxt      = r_db_cnt;
      w_hold_cnt_nxt    = r_hold_cnt;
      w_long_done_nxt   = r_long_done;
      w_key_state_nxt   = r_key_state;
      w_key_press_nxt   = 1'b0;
      w_key_release_nxt = 1'b0;
      w_key_long_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            if (!r_key_s) begin
               w_state_nxt  = PRESS_FLT;
               w_db_cnt_nxt = '0;
            end
         end

         PRESS_FLT: begin
            if (r_key_s) begin
               w_state_nxt = IDLE;
            end else if (r_db_cnt == DB_LAST) begin
               w_state_nxt     = DOWN;
               w_key_state_nxt = 1'b1;
               w_key_press_nxt = 1'b1;
               w_hold_cnt_nxt  = '0;
               w_long_done_nxt = 1'b0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + DB_W'(1);
            end
         end

         DOWN: begin
            if (r_key_s) begin
               w_state_nxt  = REL_FLT;
               w_db_cnt_nxt = '0;
            end else if (!r_long_done) begin
               // Counter parks at CNT_LONG; the done flag keeps the pulse
               // from repeating while it sits there.
               if (r_hold_cnt == HOLD_LAST) begin
                  w_key_long_nxt  = 1'b1;
                  w_long_done_nxt = 1'b1;
               end else begin
                  w_hold_cnt_nxt = r_hold_cnt + LONG_W'(1);
               end
            end
         end

         REL_FLT: begin
            // hold_cnt is left untouched here so a rejected release bounce
            // only pauses the long-press timer.
            if (!r_key_s) begin
               w_state_nxt = DOWN;
            end else if (r_db_cnt == DB_LAST) begin
               w_state_nxt       = IDLE;
               w_key_state_nxt   = 1'b0;
               w_key_release_nxt = 1'b1;
            end else begin
               w_db_cnt_nxt = r_db_cnt + DB_W'(1);
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.key_state   = r_key_state;
   assign bus.key_press   = r_key_press;
   assign bus.key_release = r_key_release;
   assign bus.key_long    = r_key_long;

endmodule

// File: tb/tb_key_debounce.sv
// Purpose: directed stimulus for key_debounce with a run-length reference model checked every cycle.
// Latency: not applicable (bench).
// Backpressure: not applicable (bench).
module tb_key_debounce;

   localparam int CNT_DB   = 9;
   localparam int CNT_LG   = 49;
   localparam int DB_LAT   = CNT_DB + 3;   // 12
   localparam int LONG_LAT = CNT_LG + 1;   // 50

   localparam int W_PRESS   = 0;
   localparam int W_RELEASE = 1;
   localparam int W_LONG    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   key_debounce_if kif ();

   key_debounce #(
      .CNT_DEBOUNCE (CNT_DB),
      .CNT_LONG     (CNT_LG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kif.master)
   );

   int checks = 0;
   int errors = 0;
   int g_edge = 0;

   always @(posedge clk) g_edge++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The debounced level flips once CNT_DB+1 consecutive synchronized samples
   // disagree with it. The hold timer counts edges where the key is pressed
   // and the two latest samples are both low; any high sample pauses it.
   bit mq[$];
   bit m_lvl, m_prev_s, m_fired, m_ks, m_want;
   int m_run, m_hold;
   bit m_press, m_rel, m_long;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq       = '{1'b1, 1'b1};
         m_lvl    = 1'b0;
         m_prev_s = 1'b1;
         m_fired  = 1'b0;
         m_run    = 0;
         m_hold   = 0;
         m_press  = 1'b0;
         m_rel    = 1'b0;
         m_long   = 1'b0;
      end else begin
         m_ks = mq.pop_front();
         mq.push_back(kif.key_n);
         m_press = 1'b0;
         m_rel   = 1'b0;
         m_long  = 1'b0;
         if (m_lvl && !m_ks && !m_prev_s && !m_fired) begin
            m_hold++;
            if (m_hold == CNT_LG + 1) begin
               m_long  = 1'b1;
               m_fired = 1'b1;
            end
         end
         m_want = !m_ks;
         if (m_want != m_lvl) m_run++;
         else                 m_run = 0;
         if (m_run == CNT_DB + 1) begin
            m_lvl = m_want;
            m_run = 0;
            if (m_want) begin
               m_press = 1'b1;
               m_hold  = 0;
               m_fired = 1'b0;
            end else begin
               m_rel = 1'b1;
            end
         end
         m_prev_s = m_ks;
      end
   end

   // ---------------- compare + pulse monitor ----------------
   int n_press = 0, n_rel = 0, n_long = 0;
   int e_press = -1, e_rel = -1, e_long = -1;

   always @(negedge clk) begin
      chk("key_state",   int'(kif.key_state),   int'(m_lvl));
      chk("key_press",   int'(kif.key_press),   int'(m_press));
      chk("key_release", int'(kif.key_release), int'(m_rel));
      chk("key_long",    int'(kif.key_long),    int'(m_long));
      if (kif.key_press)   begin n_press++; e_press = g_edge; end
      if (kif.key_release) begin n_rel++;   e_rel   = g_edge; end
      if (kif.key_long)    begin n_long++;  e_long  = g_edge; end
   end

   function automatic int cnt_of(input int which);
      if (which == W_PRESS)   return n_press;
      if (which == W_RELEASE) return n_rel;
      return n_long;
   endfunction

   function automatic int edge_of(input int which);
      if (which == W_PRESS)   return e_press;
      if (which == W_RELEASE) return e_rel;
      return e_long;
   endfunction

   // Returns the edge number that raised the next pulse, or -1 on timeout.
   task automatic wait_pulse(input int which, input int budget, output int edge_at);
      int base;
      base    = cnt_of(which);
      edge_at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (cnt_of(which) != base) begin
            edge_at = edge_of(which);
            break;
         end
      end
   endtask

   function automatic int delta(input int e, input int start);
      return (e < 0) ? -1 : e - start;
   endfunction

   task automatic hold_key(input logic v, input int n);
      kif.key_n = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"},   int'(kif.key_state),   0);
      chk({tag, "_press"},   int'(kif.key_press),   0);
      chk({tag, "_release"}, int'(kif.key_release), 0);
      chk({tag, "_long"},    int'(kif.key_long),    0);
   endtask

   initial begin
      int start, e, ep, bp, br, bl;
      kif.key_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle: held high, nothing happens.
      repeat (100) @(negedge clk);
      chk("idle_state", int'(kif.key_state), 0);
      chk("idle_pulses", n_press + n_rel + n_long, 0);

      // Clean press.
      kif.key_n = 1'b0;
      start = g_edge;
      wait_pulse(W_PRESS, 40, ep);
      chk("press_latency", delta(ep, start), DB_LAT);
      chk("press_state", int'(kif.key_state), 1);
      chk("press_no_release", n_rel, 0);

      // Long press, then no repeat.
      wait_pulse(W_LONG, 100, e);
      chk("long_latency", delta(e, ep), LONG_LAT);
      repeat (200) @(negedge clk);
      chk("long_once", n_long, 1);

      // Clean release.
      kif.key_n = 1'b1;
      start = g_edge;
      wait_pulse(W_RELEASE, 40, e);
      chk("release_latency", delta(e, start), DB_LAT);
      chk("release_state", int'(kif.key_state), 0);
      repeat (20) @(negedge clk);

      // Bounce shorter than the filter: no output change.
      bp = n_press; br = n_rel; bl = n_long;
      hold_key(1'b0, 5);
      hold_key(1'b1, 3);
      hold_key(1'b0, 5);
      hold_key(1'b1, 30);
      chk("bounce_press", n_press - bp, 0);
      chk("bounce_release", n_rel - br, 0);
      chk("bounce_state", int'(kif.key_state), 0);

      // Short press, release with a 4-cycle bounce.
      bl = n_long;
      kif.key_n = 1'b0;
      wait_pulse(W_PRESS, 40, ep);
      chk("press2_ok", (ep >= 0) ? 1 : 0, 1);
      hold_key(1'b0, 10);
      hold_key(1'b1, 2);
      hold_key(1'b0, 2);
      kif.key_n = 1'b1;
      start = g_edge;
      wait_pulse(W_RELEASE, 40, e);
      chk("bounced_release_latency", delta(e, start), DB_LAT);
      chk("bounced_release_state", int'(kif.key_state), 0);
      chk("short_press_no_long", n_long - bl, 0);
      repeat (20) @(negedge clk);

      // Reset in the middle of the press filter (db_cnt = 5).
      kif.key_n = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_flt");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start = g_edge;
      wait_pulse(W_PRESS, 40, ep);
      chk("rst_flt_press_latency", delta(ep, start), DB_LAT);

      // Reset while held down (hold_cnt = 30).
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_down");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start = g_edge;
      wait_pulse(W_PRESS, 40, ep);
      chk("rst_down_press_latency", delta(ep, start), DB_LAT);
      wait_pulse(W_LONG, 100, e);
      chk("rst_down_long_latency", delta(e, ep), LONG_LAT);

      kif.key_n = 1'b1;
      wait_pulse(W_RELEASE, 40, e);
      chk("final_release_state", int'(kif.key_state), 0);
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
